// File: rtl/fa_bist.sv
// On-chip exhaustive self-test for a 1-bit full adder.
// Drives {a,b,cin} = 0..7 and compares {cout,sum} with a+b+cin.
module fa_bist #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sum,
    input  logic       cout,
    output logic       a,
    output logic       b,
    output logic       cin,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] first_fail,
    output logic       fail_seen
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_v, w_v_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [3:0] r_err, w_err_nxt;
    logic [2:0] r_ff, w_ff_nxt;
    logic       r_fs, w_fs_nxt;
    logic       r_pass, w_pass_nxt;
    logic [2:0] r_abc;
    logic       r_busy, r_done;
    logic [1:0] w_exp;
    logic       w_mis;
    logic       w_run_nxt;

    assign w_exp = {1'b0, r_v[2]} + {1'b0, r_v[1]} + {1'b0, r_v[0]};
    assign w_mis = ({cout, sum} != w_exp);
    assign w_run_nxt = (w_state_nxt == S_DRIVE) || (w_state_nxt == S_CHECK);

    always_comb begin
        w_state_nxt = r_state;
        w_v_nxt     = r_v;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_ff_nxt    = r_ff;
        w_fs_nxt    = r_fs;
        w_pass_nxt  = r_pass;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_DRIVE;
                    w_v_nxt     = 3'd0;
                    w_cnt_nxt   = 4'd0;
                    w_err_nxt   = 4'd0;
                    w_ff_nxt    = 3'd0;
                    w_fs_nxt    = 1'b0;
                    w_pass_nxt  = 1'b0;
                end
            end
            S_DRIVE: begin
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt + 4'd1 >= LP_SETTLE) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_mis) begin
                    w_err_nxt = r_err + 4'd1;
                    if (!r_fs) begin
                        w_ff_nxt = r_v;
                        w_fs_nxt = 1'b1;
                    end
                end
                if (r_v == 3'd7) begin
                    w_state_nxt = S_DONE;
                    // pass must include the verdict on the final vector
                    w_pass_nxt  = (w_err_nxt == 4'd0);
                end else begin
                    w_state_nxt = S_DRIVE;
                    w_v_nxt     = r_v + 3'd1;
                    w_cnt_nxt   = 4'd0;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_v     <= 3'd0;
            r_cnt   <= 4'd0;
            r_err   <= 4'd0;
            r_ff    <= 3'd0;
            r_fs    <= 1'b0;
            r_pass  <= 1'b0;
            r_abc   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_v     <= w_v_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_ff    <= w_ff_nxt;
            r_fs    <= w_fs_nxt;
            r_pass  <= w_pass_nxt;
            r_abc   <= w_run_nxt ? w_v_nxt : 3'd0;
            r_busy  <= w_run_nxt;
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign {a, b, cin} = r_abc;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign err_cnt     = r_err;
    assign first_fail  = r_ff;
    assign fail_seen   = r_fs;

endmodule
